round_step_sequencer: RTL and testbench

//  Sequences the five per-round step units of the encoder datapath: column parity, rotate,

---
 rtl/round_step_sequencer.sv | 163 ++++++++++++++++
 tb/tb_round_step_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_step_sequencer.sv
// Round/step sequencer for the encoder datapath: walks colParity, rotate, permute,
// revaluate and add-round-constant for NUM_ROUNDS rounds with a per-step watchdog.
module round_step_sequencer #(
  parameter int NUM_ROUNDS   = 24,
  parameter int RND_W        = 5,
  parameter int TIMEOUT_W    = 10,
  parameter int STEP_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             colParity_ready,
  input  logic             rotate_ready,
  input  logic             permute_ready,
  input  logic             revaluate_ready,
  input  logic             addRc_ready,
  output logic [4:0]       step_go,
  output logic [4:0]       step_sel,
  output logic [RND_W-1:0] round_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_CP   = 3'd1,
    S_ROT  = 3'd2,
    S_PERM = 3'd3,
    S_REV  = 3'd4,
    S_ARC  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t               state_r;
  logic                 entry_r;
  logic [TIMEOUT_W-1:0] wd_r;

  logic                 cur_ready_s;
  logic                 last_round_s;
  logic                 wd_expire_s;
  state_t               next_step_s;

  // One-hot go/select encoding of a step state; zero for non-step states.
  function automatic logic [4:0] step_onehot(input state_t s);
    case (s)
      S_CP:    return 5'b00001;
      S_ROT:   return 5'b00010;
      S_PERM:  return 5'b00100;
      S_REV:   return 5'b01000;
      S_ARC:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // Fixed step order within a round; addRc wraps to colParity of the next round.
  function automatic state_t step_after(input state_t s);
    case (s)
      S_CP:    return S_ROT;
      S_ROT:   return S_PERM;
      S_PERM:  return S_REV;
      S_REV:   return S_ARC;
      S_ARC:   return S_CP;
      default: return IDLE;
    endcase
  endfunction

  // Select the ready line belonging to the active step; inactive steps are ignored.
  always_comb begin
    cur_ready_s = 1'b0;
    case (state_r)
      S_CP:    cur_ready_s = colParity_ready;
      S_ROT:   cur_ready_s = rotate_ready;
      S_PERM:  cur_ready_s = permute_ready;
      S_REV:   cur_ready_s = revaluate_ready;
      S_ARC:   cur_ready_s = addRc_ready;
      default: cur_ready_s = 1'b0;
    endcase
  end

  // Round/watchdog terminal-count decodes and the successor step.
  always_comb begin
    last_round_s = (round_idx == RND_W'(NUM_ROUNDS - 1));
    wd_expire_s  = (wd_r == TIMEOUT_W'(STEP_TIMEOUT - 1));
    next_step_s  = step_after(state_r);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      entry_r   <= 1'b0;
      wd_r      <= {TIMEOUT_W{1'b0}};
      step_go   <= 5'b00000;
      step_sel  <= 5'b00000;
      round_idx <= {RND_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      step_go <= 5'b00000;
      entry_r <= 1'b0;
      done    <= 1'b0;
      case (state_r)
        IDLE, S_ERR: begin
          if (start) begin
            state_r   <= S_CP;
            entry_r   <= 1'b1;
            wd_r      <= {TIMEOUT_W{1'b0}};
            step_go   <= 5'b00001;
            step_sel  <= 5'b00001;
            round_idx <= {RND_W{1'b0}};
            busy      <= 1'b1;
            err       <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        S_CP, S_ROT, S_PERM, S_REV, S_ARC: begin
          // The entry cycle never samples ready, so a stale level cannot end a step.
          if (entry_r) begin
            wd_r <= {TIMEOUT_W{1'b0}};
          end else if (cur_ready_s) begin
            if ((state_r == S_ARC) && last_round_s) begin
              state_r  <= S_DONE;
              step_sel <= 5'b00000;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state_r  <= next_step_s;
              entry_r  <= 1'b1;
              wd_r     <= {TIMEOUT_W{1'b0}};
              step_go  <= step_onehot(next_step_s);
              step_sel <= step_onehot(next_step_s);
              if (state_r == S_ARC) begin
                round_idx <= round_idx + RND_W'(1);
              end else begin
                round_idx <= round_idx;
              end
            end
          end else if (wd_expire_s) begin
            state_r  <= S_ERR;
            step_sel <= 5'b00000;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            wd_r <= wd_r + TIMEOUT_W'(1);
          end
        end
        S_DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          step_sel <= 5'b00000;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_step_sequencer.sv
// Self-checking bench for round_step_sequencer: per-cycle comparison against a
// behavioural model plus hand-computed latency, ordering and watchdog expectations.
module tb_round_step_sequencer;

  localparam int NR = 24;
  localparam int RW = 5;
  localparam int TO = 1000;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    rdy = 5'b00000;
  logic [4:0]    step_go;
  logic [4:0]    step_sel;
  logic [RW-1:0] round_idx;
  logic          busy;
  logic          done;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  round_step_sequencer #(
    .NUM_ROUNDS(NR), .RND_W(RW), .TIMEOUT_W(10), .STEP_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .colParity_ready(rdy[0]), .rotate_ready(rdy[1]), .permute_ready(rdy[2]),
    .revaluate_ready(rdy[3]), .addRc_ready(rdy[4]),
    .step_go(step_go), .step_sel(step_sel), .round_idx(round_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: mode, step number, round, age in step and low-ready wait count.
  int m_mode = M_IDLE, m_step = 0, m_round = 0, m_age = 0, m_wait = 0;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_mode = M_IDLE; m_step = 0; m_round = 0; m_age = 0; m_wait = 0;
    end else if (m_mode == M_IDLE || m_mode == M_ERR) begin
      if (start) begin
        m_mode = M_RUN; m_step = 0; m_round = 0; m_age = 0; m_wait = 0;
      end
    end else if (m_mode == M_DONE) begin
      m_mode = M_IDLE;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rdy[m_step]) begin
      m_age = 0; m_wait = 0;
      if (m_step < 4) m_step++;
      else if (m_round == NR - 1) m_mode = M_DONE;
      else begin m_round++; m_step = 0; end
    end else if (m_wait + 1 == TO) begin
      m_mode = M_ERR;
    end else begin
      m_wait++; m_age++;
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("step_go",   32'(step_go),   (m_mode == M_RUN && m_age == 0) ? (32'd1 << m_step) : 32'd0);
      check("step_sel",  32'(step_sel),  (m_mode == M_RUN) ? (32'd1 << m_step) : 32'd0);
      check("round_idx", 32'(round_idx), 32'(m_round));
      check("busy",      32'(busy),      32'(m_mode == M_RUN));
      check("done",      32'(done),      32'(m_mode == M_DONE));
      check("err",       32'(err),       32'(m_mode == M_ERR));
    end
  end

  // Ready driver: 0 = tied high, 1 = pulse 3 cycles after go, 2 = random.
  int         rdy_mode  = 0;
  bit         blk_en    = 1'b0;
  int         blk_round = 0;
  int         since_go  = 0;
  logic [4:0] last_go   = 5'b00000;
  initial forever begin
    logic [4:0] r;
    @(posedge clk);
    #1;
    if (step_go != 5'b00000) begin since_go = 0; last_go = step_go; end
    else since_go++;
    case (rdy_mode)
      0:       r = 5'b11111;
      1:       r = (since_go == 3) ? last_go : 5'b00000;
      default: r = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
    endcase
    if (blk_en && int'(round_idx) == blk_round) r[2] = 1'b0;
    rdy = r;
  end

  int go_q[$];
  int rnd_q[$];
  int g_cyc;
  int cp_cycles;

  // Pulse start and follow the encode to done or err, logging every go pulse.
  task automatic run_encode(input int bound, input bit rand_start, output int n);
    go_q.delete(); rnd_q.delete(); g_cyc = -1; cp_cycles = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    forever begin
      if (step_go != 5'b00000) begin go_q.push_back(int'(step_go)); rnd_q.push_back(int'(round_idx)); end
      if (step_go == 5'b00100 && int'(round_idx) == blk_round) g_cyc = n;
      if (step_sel == 5'b00001 && round_idx == 5'd3) cp_cycles++;
      if (done || err || n >= bound) break;
      start = rand_start ? ($urandom_range(0, 15) == 0) : 1'b0;
      tick;
      n++;
    end
    start = 1'b0;
    if (!done && !err) check("encode_timeout", 32'(n), 32'(bound + 1));
  endtask

  task automatic check_order(input string name);
    check({name, "_go_count"}, 32'(go_q.size()), 32'(5 * NR));
    for (int i = 0; i < go_q.size(); i++) begin
      check({name, "_go_order"}, 32'(go_q[i]), 32'd1 << (i % 5));
      check({name, "_go_round"}, 32'(rnd_q[i]), 32'(i / 5));
    end
  endtask

  initial begin
    int n;
    int k;
    // Reset held for three cycles.
    rst = 1'b1;
    tick;
    chk_en = 1'b1;
    tick;
    tick;
    check("rst_go", 32'(step_go), 32'd0);
    check("rst_sel", 32'(step_sel), 32'd0);
    check("rst_round", 32'(round_idx), 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b0;
    tick;

    // Ready tied high: 2 cycles per step, done 241 cycles after start.
    rdy_mode = 0;
    run_encode(2000, 1'b0, n);
    check("latency_tied", 32'(n), 32'd241);
    check("done_busy_low", 32'(busy), 32'd0);
    check("cp_entry_ignored", 32'(cp_cycles), 32'd2);
    check_order("tied");
    tick;
    check("done_one_cycle", 32'(done), 32'd0);

    // Ready 3 cycles after go: 4 cycles per step.
    rdy_mode = 1;
    tick;
    run_encode(2000, 1'b0, n);
    check("latency_delayed", 32'(n), 32'd481);
    check_order("delayed");
    tick;

    // Permute stalls in round 5: watchdog fires after 1000 wait cycles.
    rdy_mode = 0; blk_en = 1'b1; blk_round = 5;
    run_encode(3000, 1'b0, n);
    check("wd_err", 32'(err), 32'd1);
    check("wd_cycles", 32'(n - g_cyc), 32'd1001);
    check("wd_round", 32'(round_idx), 32'd5);
    check("wd_sel", 32'(step_sel), 32'd0);
    tick;
    tick;
    check("err_held", 32'(err), 32'd1);
    blk_en = 1'b0;
    run_encode(2000, 1'b0, n);
    check("restart_after_err", 32'(n), 32'd241);
    check_order("restart");
    tick;

    // Start while busy in round 7 is ignored; reset mid-rotate returns to idle.
    rdy_mode = 2;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    while (round_idx != 5'd7 && k < 5000) begin tick; k++; end
    check("reach_round7", 32'(round_idx), 32'd7);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_start_round", 32'(round_idx), 32'd7);
    check("busy_start_busy", 32'(busy), 32'd1);
    k = 0;
    while (step_sel != 5'b00010 && k < 5000) begin tick; k++; end
    check("reach_rot", 32'(step_sel), 32'd2);
    rst = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("midrst_go", 32'(step_go), 32'd0);
    check("midrst_sel", 32'(step_sel), 32'd0);
    check("midrst_round", 32'(round_idx), 32'd0);
    check("midrst_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b0;
    tick;
    tick;
    check("rst_start_forgotten", 32'(busy), 32'd0);

    // Random ready timing with stray start pulses during the encode.
    for (int r = 0; r < 3; r++) begin
      run_encode(20000, 1'b1, n);
      check("rand_done", 32'(done), 32'd1);
      check_order("rand");
      tick;
      tick;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
